cnn_layer_seq: RTL and testbench
================================

// Module: cnn_layer_seq
// PURPOSE
//  Sequencer for the conv/pool pixel datapath. Walks every pixel (1-based row/col raster) of every channel.
//  Runs the conv phase over all channels, then the pool phase over all channels.
//  Issues one PE request per pixel (req/ack handshake), then emits a one-cycle pixel_en step pulse
//  that advances the downstream pixel counter in lock-step.
//  Sits between the top-level layer start/abort control and the PE array plus pixel counter.
// PARAMETERS
//  IMG_W    8   pixels per row (col runs 1..IMG_W)
//  IMG_H    8   rows per image (row runs 1..IMG_H)
//  NUM_CH   4   channels processed per phase (ch runs 0..NUM_CH-1)
//  CW       4   width of row/col outputs
//  PW       7   width of pixel output
//  CHW      2   width of ch output
//  TIMEOUT  255 max REQ-state cycles without ack (STALL_TIMEOUT_EN only)
// PORTS
//  clk        in   1    clock, all state updates on posedge
//  rst        in   1    synchronous reset, active-high
//  start      in   1    launch layer; sampled only in IDLE
//  abort      in   1    cancel layer; sampled in any state
//  pe_ack     in   1    PE accepted current request
//  pe_req     out  1    request PE op for (conv_pool, ch, row, col)
//  pixel_en   out  1    one-cycle step pulse to pixel counter
//  conv_pool  out  1    0 = conv phase, 1 = pool phase
//  row        out  CW   current row, 1-based
//  col        out  CW   current col, 1-based
//  ch         out  CHW  current channel
//  pixel      out  PW   (row-1)*IMG_W+col, combinational from row/col
//  busy       out  1    high in REQ/STEP
//  done       out  1    one-cycle pulse on layer completion
//  err        out  1    one-cycle pulse on ack timeout (0 when feature off)
// BEHAVIOUR
//  Reset: state=IDLE, row=col=1, ch=0, conv_pool=0; pe_req, pixel_en, busy, done and err are 0.
//  All outputs decode directly from registered state; no input-to-output combinational path.
//  FSM:
//   IDLE: start=1 -> REQ; row=col=1, ch=0, conv_pool=0.
//   REQ: pe_req=1, busy=1; pe_ack=1 -> STEP; otherwise stay (req held, counters frozen).
//   STEP: pixel_en=1, busy=1; counters advance; -> REQ, or -> DONE after the final pixel.
//   DONE: done=1 for one cycle -> IDLE; counters keep their final wrapped values.
//  Advance in STEP (priority order):
//   - col<IMG_W: col+1.
//   - else if row<IMG_H: col=1, row+1.
//   - else if ch<NUM_CH-1: row=col=1, ch+1.
//   - else if conv_pool=0: row=col=1, ch=0, conv_pool=1.
//   - else (pool complete): row=col=1, ch=0, conv_pool=0, -> DONE.
//  Throughput is 2 cycles per pixel minimum, i.e. pe_ack must not be sampled in STEP.
//  pe_ack outside REQ is ignored.
//  Layer length with ack tied high:
//   - 2*IMG_W*IMG_H*NUM_CH*2 cycles of REQ/STEP, then 1 DONE cycle.
//  abort=1 in any non-IDLE state:
//   - next state is IDLE, counters reset as at rst, no done pulse.
//   - abort beats pe_ack and start in the same cycle.
//   - abort in IDLE has no effect.
//  start while busy or in DONE: ignored.
//  rst mid-layer: identical to reset; in-flight request is dropped.
// CONFIGURATION
//  STALL_TIMEOUT_EN defined:
//   - 8-bit wait counter clears on REQ entry and increments each REQ cycle without ack.
//   - On reaching TIMEOUT with no ack, err pulses 1 cycle and FSM goes to IDLE (counters reset).
//   - An ack in the same cycle as the timeout wins.
//  STALL_TIMEOUT_EN undefined: no wait counter, REQ waits indefinitely, err tied 0.
// TESTING
//  - Defaults with NUM_CH=1, pe_ack=1, start pulse -> done high exactly 257 cycles after the start-sampling edge.
//    Expect 128 pixel_en pulses; conv_pool rises after the 64th.
//  - pe_ack held 0 for 5 cycles at pixel (1,1) -> pe_req held 6 cycles, row/col stay 1/1, one pixel_en follows ack.
//  - Wrap at ch=0,row=8,col=8 (NUM_CH=4) -> after STEP: ch=1,row=1,col=1,pixel=1, conv_pool=0.
//  - abort with pe_ack at pixel 37 -> next cycle IDLE, busy=0, no pixel_en, no done.
//    Fresh start restarts at (1,1), ch=0.
//  - rst asserted mid pool phase -> all outputs at reset values the following cycle.
//  - STALL_TIMEOUT_EN, TIMEOUT=10, ack never -> err pulses once after 10 REQ cycles, then IDLE.
//    Without the macro: pe_req stays high, err=0.

Source files
------------

// File: rtl/cnn_layer_seq.sv
// Pixel/channel/phase sequencer for the conv/pool datapath: one PE request per pixel, then a step pulse.
// Optional REQ stall watchdog is compiled in with `define STALL_TIMEOUT_EN.
module cnn_layer_seq #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int NUM_CH  = 4,
    parameter int CW      = 4,
    parameter int PW      = 7,
    parameter int CHW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    input  logic           pe_ack,
    output logic           pe_req,
    output logic           pixel_en,
    output logic           conv_pool,
    output logic [CW-1:0]  row,
    output logic [CW-1:0]  col,
    output logic [CHW-1:0] ch,
    output logic [PW-1:0]  pixel,
    output logic           busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_STEP, S_DONE} state_t;

    localparam logic [CW-1:0]  IMG_W_C = CW'(IMG_W);
    localparam logic [CW-1:0]  IMG_H_C = CW'(IMG_H);
    localparam logic [CHW-1:0] CH_LAST = CHW'(NUM_CH - 1);
    localparam logic [PW-1:0]  IMG_W_P = PW'(IMG_W);

    state_t state, state_nxt;
    logic   last_pixel;
    logic   timeout_hit;
    logic   cancel;

    assign last_pixel = (col == IMG_W_C) && (row == IMG_H_C) && (ch == CH_LAST) && conv_pool;
    assign cancel     = abort && (state != S_IDLE);

`ifdef STALL_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    // Counts consecutive un-acked REQ cycles; leaving REQ clears it so every request starts fresh.
    always_ff @(posedge clk) begin
        if (rst || state != S_REQ)
            wait_cnt <= 8'd0;
        else if (!pe_ack)
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign timeout_hit = (state == S_REQ) && !pe_ack && (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= timeout_hit && !abort;
    end

    assign err = err_q;
`else
    // Without the watchdog a request waits forever.
    assign timeout_hit = (TIMEOUT < 0);
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_REQ;
            S_REQ: begin
                if (pe_ack)
                    state_nxt = S_STEP;
                else if (timeout_hit)
                    state_nxt = S_IDLE;
            end
            S_STEP: state_nxt = last_pixel ? S_DONE : S_REQ;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (cancel)
            state_nxt = S_IDLE;
    end

    // Raster advance: col, then row, then channel, then phase; pool completion wraps everything.
    always_ff @(posedge clk) begin
        if (rst || cancel || timeout_hit || (state == S_IDLE && start)) begin
            row       <= CW'(1);
            col       <= CW'(1);
            ch        <= '0;
            conv_pool <= 1'b0;
        end else if (state == S_STEP) begin
            if (col < IMG_W_C) begin
                col <= col + CW'(1);
            end else if (row < IMG_H_C) begin
                col <= CW'(1);
                row <= row + CW'(1);
            end else if (ch < CH_LAST) begin
                col <= CW'(1);
                row <= CW'(1);
                ch  <= ch + CHW'(1);
            end else begin
                col       <= CW'(1);
                row       <= CW'(1);
                ch        <= '0;
                conv_pool <= !conv_pool;
            end
        end
    end

    assign pe_req   = (state == S_REQ);
    assign pixel_en = (state == S_STEP);
    assign busy     = (state == S_REQ) || (state == S_STEP);
    assign done     = (state == S_DONE);
    assign pixel    = (PW'(row) - PW'(1)) * IMG_W_P + PW'(col);

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Self-checking bench for cnn_layer_seq: directed scenarios plus a randomized full layer against a raster model.
// Exercises the STALL_TIMEOUT_EN watchdog when that macro is defined for the build.
module tb_cnn_layer_seq;

    typedef struct packed {
        logic       cp;
        logic [1:0] ch;
        logic [3:0] row;
        logic [3:0] col;
        logic [6:0] pix;
    } coord_t;

    localparam coord_t RESET_C = coord_t'({1'b0, 2'd0, 4'd1, 4'd1, 7'd1});

    logic clk = 1'b0;
    logic rst, start, abort, pe_ack;
    logic pe_req, pixel_en, conv_pool, busy, done, err;
    logic [3:0] row, col;
    logic [1:0] ch;
    logic [6:0] pixel;

    logic start1;
    logic pe_req1, pixel_en1, conv_pool1, busy1, done1, err1;
    logic [3:0] row1, col1;
    logic [1:0] ch1;
    logic [6:0] pixel1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnn_layer_seq #(.NUM_CH(4), .TIMEOUT(10)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pe_ack(pe_ack),
        .pe_req(pe_req), .pixel_en(pixel_en), .conv_pool(conv_pool),
        .row(row), .col(col), .ch(ch), .pixel(pixel),
        .busy(busy), .done(done), .err(err)
    );

    cnn_layer_seq #(.NUM_CH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .pe_ack(1'b1),
        .pe_req(pe_req1), .pixel_en(pixel_en1), .conv_pool(conv_pool1),
        .row(row1), .col(col1), .ch(ch1), .pixel(pixel1),
        .busy(busy1), .done(done1), .err(err1)
    );

    // Pixel k of a layer in raster order: 64 pixels per channel image, nch channels per phase.
    function automatic coord_t model(int k, int nch);
        coord_t m;
        int in_img    = k % 64;
        int per_phase = 64 * nch;
        m.cp  = 1'((k / per_phase) % 2);
        m.ch  = 2'((k % per_phase) / 64);
        m.row = 4'(in_img / 8 + 1);
        m.col = 4'(in_img % 8 + 1);
        m.pix = 7'(in_img + 1);
        return m;
    endfunction

    function automatic coord_t cur();
        return coord_t'({conv_pool, ch, row, col, pixel});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cleanup();
        abort  = 1'b1;
        start  = 1'b0;
        pe_ack = 1'b0;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (cur() !== RESET_C) begin
            errors++;
            $display("[TB] FAIL reset_coord: got %h expected %h", cur(), RESET_C);
        end
        checks++;
        if ({pe_req, pixel_en, busy, done, err} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000", {pe_req, pixel_en, busy, done, err});
        end
        checks++;
        if ({pe_req1, pixel_en1, busy1, done1, err1, row1, col1, ch1, conv_pool1} !== {5'b0, 4'd1, 4'd1, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got %b/%0d/%0d/%0d/%b expected 00000/1/1/0/0",
                     {pe_req1, pixel_en1, busy1, done1, err1}, row1, col1, ch1, conv_pool1);
        end
    endtask

    task automatic test_layer_length();
        int cyc = 0, done_cyc = -1, pe_cnt = 0, cp_at = -1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        cyc = 1;
        for (int i = 0; i < 400; i++) begin
            if (pixel_en1) pe_cnt++;
            if (conv_pool1 && cp_at < 0) cp_at = pe_cnt;
            if (done1) begin
                done_cyc = cyc;
                break;
            end
            tick();
            cyc++;
        end
        checks++;
        if (done_cyc != 257) begin
            errors++;
            $display("[TB] FAIL layer_done_cycle: got %0d expected 257", done_cyc);
        end
        checks++;
        if (pe_cnt != 128) begin
            errors++;
            $display("[TB] FAIL layer_pixel_en_count: got %0d expected 128", pe_cnt);
        end
        checks++;
        if (cp_at != 64) begin
            errors++;
            $display("[TB] FAIL layer_conv_pool_rise: got %0d expected 64", cp_at);
        end
        tick();
        checks++;
        if ({done1, busy1} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL layer_done_pulse: got done/busy %b expected 00", {done1, busy1});
        end
    endtask

    task automatic test_stall();
        int req_cnt = 0, pe_cnt = 0;
        bit moved = 0;
        start  = 1'b1;
        pe_ack = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (pe_req && pe_cnt == 0) req_cnt++;
            if (pe_req && pe_cnt == 0 && (row != 4'd1 || col != 4'd1)) moved = 1;
            if (pixel_en) pe_cnt++;
            pe_ack = (i == 6);
            tick();
        end
        checks++;
        if (req_cnt != 6) begin
            errors++;
            $display("[TB] FAIL stall_req_cycles: got %0d expected 6", req_cnt);
        end
        checks++;
        if (pe_cnt != 1) begin
            errors++;
            $display("[TB] FAIL stall_pixel_en_count: got %0d expected 1", pe_cnt);
        end
        checks++;
        if (moved) begin
            errors++;
            $display("[TB] FAIL stall_counters_frozen: got moved=1 expected 0");
        end
        checks++;
        if ({row, col} !== {4'd1, 4'd2}) begin
            errors++;
            $display("[TB] FAIL stall_after_step: got row %0d col %0d expected 1 2", row, col);
        end
        cleanup();
    endtask

    task automatic test_wrap();
        bit found = 0;
        coord_t exp_c = coord_t'({1'b0, 2'd1, 4'd1, 4'd1, 7'd1});
        start  = 1'b1;
        pe_ack = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (pixel_en && ch == 2'd0 && row == 4'd8 && col == 4'd8) begin
                found = 1;
                tick();
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL wrap_reached: got 0 expected 1");
        end
        checks++;
        if (cur() !== exp_c || pe_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_coord: got %h req %b expected %h req 1", cur(), pe_req, exp_c);
        end
        cleanup();
    endtask

    task automatic test_abort();
        bit found = 0;
        int stray = 0;
        start  = 1'b1;
        pe_ack = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pe_req && pixel == 7'd37 && ch == 2'd0 && !conv_pool) begin
                found = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL abort_reach_pixel37: got 0 expected 1");
        end
        abort  = 1'b1;
        start  = 1'b1;
        pe_ack = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        checks++;
        if ({pe_req, pixel_en, busy, done} !== 4'b0 || cur() !== RESET_C) begin
            errors++;
            $display("[TB] FAIL abort_idle: got ctrl %b coord %h expected 0000 %h",
                     {pe_req, pixel_en, busy, done}, cur(), RESET_C);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pixel_en || done || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("[TB] FAIL abort_quiet: got %0d active cycles expected 0", stray);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pe_req !== 1'b1 || cur() !== RESET_C) begin
            errors++;
            $display("[TB] FAIL abort_restart: got req %b coord %h expected req 1 coord %h", pe_req, cur(), RESET_C);
        end
        cleanup();
    endtask

    task automatic test_rst_mid();
        bit found = 0;
        start  = 1'b1;
        pe_ack = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if (conv_pool && pixel == 7'd10) begin
                found = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL rst_mid_reach_pool: got 0 expected 1");
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pe_ack = 1'b0;
        checks++;
        if (cur() !== RESET_C || {pe_req, pixel_en, busy, done, err} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid: got coord %h ctrl %b expected %h 00000",
                     cur(), {pe_req, pixel_en, busy, done, err}, RESET_C);
        end
    endtask

    task automatic test_timeout();
        start  = 1'b1;
        pe_ack = 1'b0;
        tick();
        start = 1'b0;
`ifdef STALL_TIMEOUT_EN
        begin
            int err_at = -1, err_cnt = 0, req_n = 0;
            for (int i = 1; i <= 20; i++) begin
                if (err) begin
                    err_cnt++;
                    if (err_at < 0) err_at = i;
                end
                if (pe_req) req_n++;
                tick();
            end
            checks++;
            if (err_at != 11 || err_cnt != 1) begin
                errors++;
                $display("[TB] FAIL timeout_err: got at %0d count %0d expected at 11 count 1", err_at, err_cnt);
            end
            checks++;
            if (req_n != 10 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL timeout_idle: got req cycles %0d busy %b expected 10 0", req_n, busy);
            end
        end
`else
        begin
            int req_n = 0, err_n = 0;
            for (int i = 0; i < 30; i++) begin
                if (pe_req) req_n++;
                if (err) err_n++;
                tick();
            end
            checks++;
            if (req_n != 30 || err_n != 0) begin
                errors++;
                $display("[TB] FAIL no_timeout: got req %0d err %0d expected 30 0", req_n, err_n);
            end
        end
`endif
        cleanup();
    endtask

    // Random ack/start traffic over a whole 4-channel layer; start while busy or in DONE must be ignored.
    task automatic test_random_layer();
        int k = 0, stall = 0, done_seen = 0;
        bit exp_step = 0;
        coord_t exp_c;
        start = 1'b1;
        pe_ack = 1'b0;
        tick();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            checks++;
            if (pixel_en !== exp_step) begin
                errors++;
                $display("[TB] FAIL rand_pixel_en k=%0d: got %b expected %b", k, pixel_en, exp_step);
            end
            if (pe_req || pixel_en) begin
                exp_c = model(k, 4);
                checks++;
                if (cur() !== exp_c) begin
                    errors++;
                    $display("[TB] FAIL rand_coord k=%0d: got %h expected %h", k, cur(), exp_c);
                end
            end
            if (pixel_en) k++;
            if (done) begin
                done_seen = 1;
                break;
            end
            pe_ack = (stall >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
            start  = 1'($urandom_range(0, 1));
            if (pe_req && !pe_ack) stall++;
            else stall = 0;
            exp_step = pe_req && pe_ack;
            tick();
        end
        checks++;
        if (!done_seen || k != 512) begin
            errors++;
            $display("[TB] FAIL rand_done: got done %0d pixels %0d expected 1 512", done_seen, k);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_start_in_done: got busy %b done %b expected 0 0", busy, done);
        end
        cleanup();
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        pe_ack = 1'b0;
        start1 = 1'b0;
        test_reset();
        test_layer_length();
        test_stall();
        test_wrap();
        test_abort();
        test_rst_mid();
        test_timeout();
        test_random_layer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
